// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiply/divide opcodes, FSM states, widths.
package mips_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned MDU_CNT_W = 6;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_abs.sv
// Conditional two's-complement negate: magnitude of a signed operand, or forced negate for result fixup.
module mdu_abs #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         is_signed,
  input  logic         negate,
  output logic [W-1:0] magnitude,
  output logic         sign
);

  // Sign only counts for signed interpretation; negate forces the fixup path.
  always_comb begin
    sign      = is_signed & value[W-1];
    magnitude = (sign | negate) ? (W'(0) - value) : value;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
module mult_div_unit #(
  parameter int unsigned WIDTH = mips_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mips_pkg::*;

  localparam int unsigned            CNT_W     = MDU_CNT_W;
  localparam logic [CNT_W-1:0]       LAST_ITER = CNT_W'(31);

  mdu_state_e          state, state_next;
  mdu_op_e             op_q;
  logic [WIDTH-1:0]    mag_a, mag_b, raw_a, shreg;
  logic                res_sign, rem_sign;
  logic [2*WIDTH-1:0]  acc;
  logic [WIDTH-1:0]    rem;
  logic [CNT_W-1:0]    cnt;

  logic                busy_next, done_next, dbz_next;
  logic [WIDTH-1:0]    hi_next, lo_next;

  logic                launch_c, in_signed_c, q_is_div_c, q_signed_c, div_zero_c, qbit_c;
  logic [WIDTH-1:0]    a_mag_c, b_mag_c;
  logic                a_sign_c, b_sign_c;
  logic [WIDTH:0]      mul_sum_c, div_shift_c, div_diff_c;
  logic [2*WIDTH-1:0]  prod_fix_c;
  logic [WIDTH-1:0]    quo_fix_c, rem_fix_c;
  logic                unused_prod_sign, unused_quo_sign, unused_rem_sign;

  assign launch_c    = (state == IDLE) && start;
  assign in_signed_c = ~op[0];
  assign q_is_div_c  = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
  assign q_signed_c  = (op_q == MDU_MULT) || (op_q == MDU_DIV);
  assign div_zero_c  = (mag_b == '0);

  // Operand magnitudes at launch.
  mdu_abs #(.W(WIDTH)) u_abs_a (
    .value(operand_a), .is_signed(in_signed_c), .negate(1'b0),
    .magnitude(a_mag_c), .sign(a_sign_c)
  );
  mdu_abs #(.W(WIDTH)) u_abs_b (
    .value(operand_b), .is_signed(in_signed_c), .negate(1'b0),
    .magnitude(b_mag_c), .sign(b_sign_c)
  );

  // Sign fixup of the unsigned-magnitude results.
  mdu_abs #(.W(2*WIDTH)) u_fix_prod (
    .value(acc), .is_signed(1'b0), .negate(q_signed_c & res_sign),
    .magnitude(prod_fix_c), .sign(unused_prod_sign)
  );
  mdu_abs #(.W(WIDTH)) u_fix_quo (
    .value(shreg), .is_signed(1'b0), .negate(q_signed_c & res_sign),
    .magnitude(quo_fix_c), .sign(unused_quo_sign)
  );
  mdu_abs #(.W(WIDTH)) u_fix_rem (
    .value(rem), .is_signed(1'b0), .negate(q_signed_c & rem_sign),
    .magnitude(rem_fix_c), .sign(unused_rem_sign)
  );

  // One shift-add step (multiplier LSB first) and one restoring-divide step (dividend MSB first).
  always_comb begin
    mul_sum_c   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (shreg[0] ? mag_a : '0)};
    div_shift_c = {rem, shreg[WIDTH-1]};
    div_diff_c  = div_shift_c - {1'b0, mag_b};
    qbit_c      = ~div_diff_c[WIDTH];
  end

  // Next state and next registered outputs.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    dbz_next   = 1'b0;
    hi_next    = hi;
    lo_next    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
        end else begin
          if (mthi) hi_next = operand_a;
          if (mtlo) lo_next = operand_a;
        end
      end
      CALC: begin
        if (cnt == LAST_ITER) state_next = FIX;
      end
      FIX: begin
        state_next = IDLE;
        done_next  = 1'b1;
        if (q_is_div_c) begin
          if (div_zero_c) begin
            hi_next  = raw_a;
            lo_next  = '1;
            dbz_next = 1'b1;
          end else begin
            hi_next = rem_fix_c;
            lo_next = quo_fix_c;
          end
        end else begin
          hi_next = prod_fix_c[2*WIDTH-1:WIDTH];
          lo_next = prod_fix_c[WIDTH-1:0];
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state       <= state_next;
      busy        <= busy_next;
      done        <= done_next;
      div_by_zero <= dbz_next;
      hi          <= hi_next;
      lo          <= lo_next;
    end
  end

  // Datapath: operand capture at launch, one iteration per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MDU_MULT;
      mag_a    <= '0;
      mag_b    <= '0;
      raw_a    <= '0;
      shreg    <= '0;
      res_sign <= 1'b0;
      rem_sign <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
    end else if (launch_c) begin
      op_q     <= mdu_op_e'(op);
      mag_a    <= a_mag_c;
      mag_b    <= b_mag_c;
      raw_a    <= operand_a;
      shreg    <= op[1] ? a_mag_c : b_mag_c;
      res_sign <= a_sign_c ^ b_sign_c;
      rem_sign <= a_sign_c;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (q_is_div_c) begin
        rem   <= qbit_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
        shreg <= {shreg[WIDTH-2:0], qbit_c};
      end else begin
        acc   <= {mul_sum_c, acc[WIDTH-1:1]};
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model plus directed vectors.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from integer arithmetic.
  function automatic void compute(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    rz = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
      2'b01: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          rh = a; rl = 32'hFFFF_FFFF; rz = 1'b1;
        end else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          rh = sr[31:0]; rl = sq[31:0];
        end else begin
          up = ua / ub; rh = 32'(ua % ub); rl = up[31:0];
        end
      end
    endcase
  endfunction

  // Model: a launch completes 33 edges later; HI/LO only move then or on an idle MTHI/MTLO.
  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_rem == 0) begin
        if (start) begin
          compute(op, operand_a, operand_b, p_hi, p_lo, p_dbz);
          m_rem = 33;
        end else begin
          if (mthi) m_hi = operand_a;
          if (mtlo) m_lo = operand_a;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dbz = p_dbz;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'b0, busy}, {31'b0, (m_rem != 0)});
      check("cyc_done", {31'b0, done}, {31'b0, m_done});
      check("cyc_dbz",  {31'b0, div_by_zero}, {31'b0, m_dbz});
      check("cyc_hi",   hi, m_hi);
      check("cyc_lo",   lo, m_lo);
    end
  end

  // Wait for done with a cycle budget; optionally inject a MULTU 2*3 start at cycle inject_at.
  task automatic wait_done(input int inject_at, output int n);
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      start = (n == inject_at);
      mthi  = 1'b0;
      mtlo  = 1'b0;
      if (n == inject_at) begin
        op = 2'b01; operand_a = 32'd2; operand_b = 32'd3;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic ez);
    int n;
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    wait_done(0, n);
    check({name, "_latency"}, 32'(n), 32'd34);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
    check({name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
    check({name, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen_done;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    #2 rst_n = 1'b1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7_2",  2'b11, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run_op("divu_zero", 2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
    run_op("div_zero",  2'b10, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
    run_op("mult_pos_neg", 2'b00, 32'd100000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFC_F2C0, 1'b0);
    run_op("div_rem_neg",  2'b10, 32'd17, 32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFFD, 1'b0);

    // Start during busy is dropped; start in the done cycle launches with no bubble.
    @(negedge clk);
    op = 2'b11; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    wait_done(5, n);
    check("busy_start_latency", 32'(n), 32'd34);
    check("busy_start_hi", hi, 32'd2);
    check("busy_start_lo", lo, 32'd14);
    op = 2'b01; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
    wait_done(0, n);
    check("b2b_latency", 32'(n), 32'd34);
    check("b2b_hi", hi, 32'd0);
    check("b2b_lo", lo, 32'd6);

    // MTHI together with start is ignored.
    @(negedge clk);
    op = 2'b01; operand_a = 32'h5555; operand_b = 32'd1; start = 1'b1; mthi = 1'b1;
    wait_done(0, n);
    check("mthi_with_start_hi", hi, 32'd0);
    check("mthi_with_start_lo", lo, 32'h5555);

    // MTHI/MTLO in idle.
    @(negedge clk);
    mthi = 1'b1; operand_a = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    mtlo = 1'b1; operand_a = 32'hABCD;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'hABCD);
    check("mtlo_keeps_hi", hi, 32'h1234);

    // Reset in the middle of an operation.
    @(negedge clk);
    op = 2'b01; operand_a = 32'd9; operand_b = 32'd9; start = 1'b1;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("midrst_no_done", {31'b0, seen_done}, 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
